// File: rtl/aidc_lite_code_split.sv
// Code splitter: strips the 2-bit block prefix and serves an MSB-aligned window
// of unconsumed code bits, refilling a 128-bit buffer one 64-bit word at a time.
module aidc_lite_code_split #(
  parameter int DATA_SIZE = 66,
  parameter int BUF_SIZE  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [10:0]          blk_size_i,
  output logic                 busy_o,
  output logic                 rd_en_o,
  output logic [3:0]           rd_addr_o,
  input  logic [63:0]          rd_data_i,
  output logic [1:0]           prefix_o,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] data_o,
  input  logic                 consume_i,
  input  logic [6:0]           size_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           state_o
);

  // Handshake: a code of size_i bits is taken on a rising edge where valid_o and
  // consume_i are both high; data_o is stable while valid_o is high until then.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH0 = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [10:0] LP_DATA = 11'(DATA_SIZE);

  state_t              r_state;
  state_t              w_state_n;
  logic [BUF_SIZE-1:0] r_buf;
  logic [7:0]          r_count;
  logic [10:0]         r_rem;
  logic [4:0]          r_nwords;
  logic [4:0]          r_fetched;
  logic                r_rd_en;
  logic [3:0]          r_rd_addr;
  logic [1:0]          r_prefix;
  logic                r_valid;
  logic                r_done;
  logic                r_err;

  logic                w_start_ok;
  logic                w_consume;
  logic                w_size_bad;
  logic [10:0]         w_eff;
  logic [BUF_SIZE-1:0] w_buf_sh;
  logic [7:0]          w_cnt_sh;
  logic [10:0]         w_rem_n;
  logic                w_refill;
  logic [BUF_SIZE-1:0] w_buf_n;
  logic [7:0]          w_cnt_n;
  logic                w_issue;
  logic [10:0]         w_win_min;
  logic                w_valid_n;
  logic [DATA_SIZE-1:0] w_mask;

  assign w_start_ok = start_i && (blk_size_i >= 11'd2) && (blk_size_i <= 11'd1024);
  assign w_consume  = r_valid && consume_i;
  assign w_size_bad = (size_i == 7'd0) || ({4'b0, size_i} > r_rem) || (size_i > 7'(DATA_SIZE));

  // An illegal size is clamped to the remaining bits so the block ends cleanly.
  assign w_eff    = !w_consume ? 11'd0 : (w_size_bad ? r_rem : {4'b0, size_i});
  assign w_buf_sh = r_buf << w_eff;
  assign w_cnt_sh = ({3'b0, r_count} >= w_eff) ? (r_count - w_eff[7:0]) : 8'd0;
  assign w_rem_n  = r_rem - w_eff;

  // Shift first, then append the returning word at the post-shift count.
  assign w_refill = (r_state == S_RUN) && r_rd_en;
  assign w_buf_n  = w_buf_sh |
                    (w_refill ? ({rd_data_i, {(BUF_SIZE-64){1'b0}}} >> w_cnt_sh) : '0);
  assign w_cnt_n  = w_cnt_sh + (w_refill ? 8'd64 : 8'd0);

  assign w_issue = (r_state == S_RUN) && !r_rd_en && (w_cnt_sh <= 8'd64) &&
                   (r_fetched < r_nwords) && (w_rem_n != 11'd0);

  assign w_win_min = (w_rem_n < LP_DATA) ? w_rem_n : LP_DATA;
  assign w_valid_n = (r_state == S_RUN) && (w_rem_n != 11'd0) && ({3'b0, w_cnt_n} >= w_win_min);

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_n = S_FETCH0;
      S_FETCH0: if (r_rd_en) w_state_n = S_RUN;
      S_RUN:    if (r_rem == 11'd0) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_count   <= 8'd0;
      r_rem     <= 11'd0;
      r_nwords  <= 5'd0;
      r_fetched <= 5'd0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= 4'd0;
      r_prefix  <= 2'd0;
      r_valid   <= 1'b0;
      r_done    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_rd_en <= 1'b0;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_nwords  <= 5'((blk_size_i + 11'd63) >> 6);
            r_rem     <= blk_size_i - 11'd2;
            r_fetched <= 5'd0;
            r_count   <= 8'd0;
            r_buf     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
          end else if (start_i) begin
            r_err <= 1'b1;
          end
        end
        S_FETCH0: begin
          if (!r_rd_en) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= 4'd0;
            r_fetched <= 5'd1;
          end else begin
            r_prefix <= rd_data_i[63:62];
            r_buf    <= {rd_data_i[61:0], {(BUF_SIZE-62){1'b0}}};
            r_count  <= 8'd62;
          end
        end
        S_RUN: begin
          if (r_rem == 11'd0) begin
            r_done  <= 1'b1;
            r_buf   <= '0;
            r_count <= 8'd0;
          end else begin
            r_buf   <= w_buf_n;
            r_count <= w_cnt_n;
            r_rem   <= w_rem_n;
            r_valid <= w_valid_n;
            if (w_issue) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_fetched[3:0];
              r_fetched <= r_fetched + 5'd1;
            end
            if (w_consume && w_size_bad) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_mask = (r_rem >= LP_DATA) ? {DATA_SIZE{1'b1}} : ~({DATA_SIZE{1'b1}} >> r_rem);

  assign busy_o    = (r_state != S_IDLE);
  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rd_addr;
  assign prefix_o  = r_prefix;
  assign valid_o   = r_valid;
  assign data_o    = r_buf[BUF_SIZE-1 -: DATA_SIZE] & w_mask;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_aidc_lite_code_split.sv
// Directed bench for aidc_lite_code_split: bit-stream model of the packed block,
// per-scenario tasks with inline comparisons, read-sequence monitor.
module tb_aidc_lite_code_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [10:0] blk_size_i;
  logic        busy_o;
  logic        rd_en_o;
  logic [3:0]  rd_addr_o;
  logic [63:0] rd_data_i;
  logic [1:0]  prefix_o;
  logic        valid_o;
  logic [65:0] data_o;
  logic        consume_i;
  logic [6:0]  size_i;
  logic        done_o;
  logic        err_o;
  logic [1:0]  state_o;

  logic [63:0]   mem [16];
  logic [1023:0] stream;
  int            pos;
  int            rem;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            mon_on = 1'b0;
  bit            prev_rd = 1'b0;
  int            rd_cnt = 0;

  always #5 clk = ~clk;

  assign rd_data_i = mem[rd_addr_o];

  aidc_lite_code_split #(.DATA_SIZE(66), .BUF_SIZE(128)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .blk_size_i(blk_size_i),
    .busy_o(busy_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .prefix_o(prefix_o), .valid_o(valid_o), .data_o(data_o),
    .consume_i(consume_i), .size_i(size_i), .done_o(done_o), .err_o(err_o),
    .state_o(state_o)
  );

  // Read monitor: addresses must run 0,1,2,... and a pulse never lasts two cycles.
  always @(negedge clk) begin
    if (mon_on && rd_en_o) begin
      n_cmp++;
      if (rd_addr_o !== 4'(rd_cnt)) begin
        n_bad++;
        $display("FAIL rd_addr: got %0d want %0d", rd_addr_o, rd_cnt);
      end
      n_cmp++;
      if (prev_rd) begin
        n_bad++;
        $display("FAIL rd_outstanding: got back-to-back rd_en_o want single pulse");
      end
      rd_cnt++;
    end
    prev_rd = rd_en_o;
  end

  function automatic logic [65:0] exp_window();
    logic [1023:0] t;
    logic [65:0]   m;
    t = stream << pos;
    m = (rem >= 66) ? {66{1'b1}} : ~({66{1'b1}} >> rem);
    return t[1023 -: 66] & m;
  endfunction

  task automatic load_random();
    for (int i = 0; i < 16; i++) mem[i] = {$urandom(), $urandom()};
    for (int i = 0; i < 16; i++) stream[1023 - 64*i -: 64] = mem[i];
  endtask

  task automatic start_block(input int blk);
    start_i    = 1'b1;
    blk_size_i = 11'(blk);
    pos = 2;
    rem = blk - 2;
    rd_cnt = 0;
    mon_on = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume_code(input int sz, input string tag);
    bit ok;
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s valid_timeout: got valid_o=0 want 1", tag);
    end else begin
      n_cmp++;
      if (data_o !== exp_window()) begin
        n_bad++;
        $display("FAIL %s window: got %h want %h", tag, data_o, exp_window());
      end
      consume_i = 1'b1;
      size_i    = 7'(sz);
      @(negedge clk);
      consume_i = 1'b0;
      pos += sz;
      rem -= (sz == 0 || sz > rem || sz > 66) ? rem : sz;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (done_o) break;
      @(negedge clk);
    end
    n_cmp++;
    if ({done_o, busy_o, valid_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s done: got done/busy/valid=%b want 100", tag, {done_o, busy_o, valid_o});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; blk_size_i = 11'd0; consume_i = 1'b0; size_i = 7'd0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_o, rd_en_o, rd_addr_o, valid_o, prefix_o, done_o, err_o, state_o} !== 13'b0_0_0000_0_00_1_0_00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000000001000",
               {busy_o, rd_en_o, rd_addr_o, valid_o, prefix_o, done_o, err_o, state_o});
    end
    n_cmp++;
    if (data_o !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_refill();
    load_random();
    start_block(156);
    consume_code(6, "refill_c0");
    for (int k = 0; k < 4; k++) consume_code(34, "refill_c34");
    consume_code(12, "refill_last");
    wait_done("refill");
    n_cmp++;
    if (rd_cnt !== 3) begin
      n_bad++;
      $display("FAIL refill_reads: got %0d want 3", rd_cnt);
    end
    n_cmp++;
    if ({prefix_o, err_o} !== {stream[1023:1022], 1'b0}) begin
      n_bad++;
      $display("FAIL refill_prefix_err: got %b want %b", {prefix_o, err_o}, {stream[1023:1022], 1'b0});
    end
  endtask

  task automatic test_busy_start();
    load_random();
    start_block(200);
    consume_code(20, "busy_c0");
    start_i = 1'b1;
    blk_size_i = 11'd8;
    @(negedge clk);
    start_i = 1'b0;
    n_cmp++;
    if ({busy_o, err_o, prefix_o} !== {1'b1, 1'b0, stream[1023:1022]}) begin
      n_bad++;
      $display("FAIL busy_ignore: got %b want %b", {busy_o, err_o, prefix_o}, {1'b1, 1'b0, stream[1023:1022]});
    end
    consume_code(66, "busy_c1");
    consume_code(66, "busy_c2");
    consume_code(46, "busy_c3");
    wait_done("busy");
    n_cmp++;
    if (rd_cnt !== 4) begin
      n_bad++;
      $display("FAIL busy_reads: got %0d want 4", rd_cnt);
    end
  endtask

  task automatic test_concurrent();
    int codes = 0;
    int sz;
    load_random();
    start_block(1024);
    consume_i = 1'b1;
    size_i    = 7'd64;
    for (int i = 0; i < 400 && rem > 0; i++) begin
      if (valid_o) begin
        n_cmp++;
        if (data_o !== exp_window()) begin
          n_bad++;
          $display("FAIL conc_window%0d: got %h want %h", codes, data_o, exp_window());
        end
        sz = (rem < 64) ? rem : 64;
        size_i = 7'(sz);
        pos += sz;
        rem -= sz;
        codes++;
      end
      @(negedge clk);
    end
    consume_i = 1'b0;
    wait_done("conc");
    n_cmp++;
    if ({codes, rd_cnt, rem} !== {32'd16, 32'd16, 32'd0}) begin
      n_bad++;
      $display("FAIL conc_counts: got codes=%0d reads=%0d rem=%0d want 16 16 0", codes, rd_cnt, rem);
    end
  endtask

  task automatic test_errors();
    start_i = 1'b1;
    blk_size_i = 11'd1100;
    @(negedge clk);
    start_i = 1'b0;
    n_cmp++;
    if ({err_o, busy_o, done_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL err_bad_blk: got err/busy/done=%b want 101", {err_o, busy_o, done_o});
    end
    load_random();
    start_block(12);
    n_cmp++;
    if ({err_o, busy_o} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_clear: got err/busy=%b want 01", {err_o, busy_o});
    end
    consume_code(20, "err_size");
    n_cmp++;
    if ({err_o, valid_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL err_oversize: got err/valid=%b want 10", {err_o, valid_o});
    end
    wait_done("err");
  endtask

  task automatic test_reset_mid();
    load_random();
    start_block(156);
    consume_code(6, "mid_c0");
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_o, rd_en_o, rd_addr_o, valid_o, prefix_o, done_o, err_o} !== 11'b0_0_0000_0_00_1_0 ||
        data_o !== 66'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b data %h want 00000000010 data 0",
               {busy_o, rd_en_o, rd_addr_o, valid_o, prefix_o, done_o, err_o}, data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem[0] = 64'h7AC0_0000_0000_0000;
    start_block(8);
    n_cmp++;
    if ({busy_o, rd_en_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL mid_c0: got busy/rd_en=%b want 10", {busy_o, rd_en_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_en_o, rd_addr_o} !== 5'b1_0000) begin
      n_bad++;
      $display("FAIL mid_c1: got rd_en/addr=%b want 10000", {rd_en_o, rd_addr_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({prefix_o, valid_o, rd_en_o} !== 4'b01_0_0) begin
      n_bad++;
      $display("FAIL mid_c2: got prefix/valid/rd_en=%b want 0100", {prefix_o, valid_o, rd_en_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({valid_o, data_o} !== {1'b1, 6'b111010, 60'd0}) begin
      n_bad++;
      $display("FAIL mid_c3: got valid=%b data=%h want 1 %h", valid_o, data_o, {6'b111010, 60'd0});
    end
    consume_i = 1'b1;
    size_i = 7'd6;
    @(negedge clk);
    consume_i = 1'b0;
    n_cmp++;
    if ({valid_o, done_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_c4: got valid/done=%b want 00", {valid_o, done_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o, valid_o, err_o} !== 4'b1000) begin
      n_bad++;
      $display("FAIL mid_c5: got done/busy/valid/err=%b want 1000", {done_o, busy_o, valid_o, err_o});
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_busy_start();
    test_concurrent();
    test_errors();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aidc_lite_code_split.md
Name: aidc_lite_code_split

Overview:
- Decompression-side counterpart of the code concatenation stage.
- Reads a packed compressed block (up to 16 x 64-bit words, 2-bit prefix first) from the block buffer and strips and exports the prefix.
- Presents an MSB-aligned window of unconsumed code bits to the downstream decoder.
- The decoder returns the length of each code it consumes; the block shifts the window and refills from memory, one outstanding read at a time.

Parameters:
- DATA_SIZE, 66, window width in bits; must be ≥ 2 and ≤ 66.
- BUF_SIZE, 128, internal bit-buffer width; fixed at 2 x 64.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  start decoding a block; accepted only in IDLE
- blk_size_i  in  11  block size in bits, including the 2-bit prefix
- busy_o  out  1  high while not IDLE
- rd_en_o  out  1  block-buffer read request
- rd_addr_o  out  4  block-buffer word address
- rd_data_i  in  64  read data; valid the cycle after rd_en_o; bit 63 is the first bit
- prefix_o  out  2  prefix of the current block; held until next start
- valid_o  out  1  window valid
- data_o  out  DATA_SIZE  window; first unconsumed bit at data_o[DATA_SIZE-1]; bits past the block end read 0
- consume_i  in  1  decoder consumes size_i bits; effective only when valid_o=1
- size_i  in  7  bits consumed, 1..DATA_SIZE
- done_o  out  1  block fully consumed / idle; level signal
- err_o  out  1  sticky protocol error; cleared on the next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE, rd_en_o=0, rd_addr_o=0, valid_o=0, data_o=0, prefix_o=0, done_o=1, err_o=0, busy_o=0; buffer count, word counter and remaining counter all 0.
- State IDLE:
  - start_i=1 with 2 ≤ blk_size_i ≤ 1024:
    - latch nwords=(blk_size_i+63)>>6 and remaining=blk_size_i-2;
    - done_o←0, err_o←0;
    - go to FETCH0.
  - start_i=1 with an illegal blk_size_i: err_o←1, stay IDLE.
- State FETCH0:
  - Next cycle, rd_en_o=1, rd_addr_o=0.
  - Cycle after that, capture rd_data_i: prefix_o←rd_data_i[63:62], buffer←rd_data_i[61:0] left-aligned, count←62.
  - Go to RUN.
- State RUN, refill:
  - rd_en_o is a registered pulse, issued when count ≤ 64 after this cycle's consume, words_fetched < nwords, and no read is outstanding.
  - rd_addr_o increments per read.
  - Returned word is appended at bit position count (post-consume) of the MSB-aligned buffer; count += 64.
- valid_o (registered):
  - 1 in RUN when count ≥ min(DATA_SIZE, remaining) and remaining > 0.
  - Buffer bits beyond remaining are masked to 0 in data_o.
- Consume (valid_o & consume_i):
  - Buffer shifts left by size_i; count -= size_i; remaining -= size_i.
  - The window updates on the next cycle; valid_o re-evaluates on that cycle.
  - Back-to-back consumes are allowed every cycle while valid_o stays 1.
- Simultaneous consume and refill return in one cycle: shift first, then append at the new count. count never exceeds 128.
- size_i = 0 or size_i > remaining:
  - err_o←1; consume is clamped to remaining, so the block terminates.
- consume_i while valid_o=0: ignored, no error.
- Termination: when remaining reaches 0, in the next cycle valid_o=0, done_o=1, busy_o=0, state IDLE.
  - A late in-flight read, if any, is still absorbed and discarded.
- start_i while busy: ignored, no error.
- Arithmetic widths: remaining 11 bits, count 8 bits, words_fetched 5 bits; no wrap, since nwords ≤ 16.
- rst asserted mid-block: immediate return to reset values. An outstanding read is discarded; rd_data_i is not sampled after reset.

Test Plan:
- Reset mid-block: assert rst mid-RUN → all outputs at reset values next edge. New start_i, blk_size_i=8, mem[0]=0x7AC0_0000_0000_0000 → fresh run proceeds correctly:
  - start at c0, rd_en_o=1/addr 0 at c1, capture at c2;
  - prefix_o=2'b01, valid_o=1 at c3 with data_o[65:60]=6'b111010, other bits 0;
  - consume size 6 → done_o=1, valid_o=0 at c5.
- Refill timing: blk_size_i=156 (prefix + 6 + 4x34 + ...), three words, decoder consumes 6 then 34s → codes match the packed reference stream; reads at addresses 0,1,2 only; never more than 1 outstanding.
- Concurrent refill: consume_i held high every cycle with size_i=64-sized codes, 1024-bit block → no lost or duplicated bits; count ≤ 128 throughout; refill and consume land in the same cycle at least once.
- Error cases:
  - size_i=20 with remaining=10 → err_o=1, block ends, done_o=1.
  - start_i with blk_size_i=1100 → err_o=1, busy_o stays 0.
- Busy start: start_i pulsed while busy_o=1 → ignored; current block output unchanged.
